// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_e;

    localparam int unsigned DEFAULT_MEM_LATENCY = 2;

    // A latency of 1 still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_access_timer.sv
// Loadable down-counter that times how long a memory command is held.
module mem_access_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned CW = cnt_width(MEM_LATENCY);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes instruction-fetch and load/store accesses onto one memory port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int unsigned RR_MODE     = 0
) (
    input  logic          clk,
    input  logic          pc_reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          stall,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    gnt_e          gnt_q, gnt_d;
    gnt_e          last_q, last_d;
    op_e           op_q, op_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;

    logic d_req, if_elig, d_elig, pick_data;
    logic tmr_load, tmr_dec, tmr_zero;

    mem_access_timer #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_timer (
        .clk_i (clk),
        .rst_i (pc_reset),
        .load_i(tmr_load),
        .dec_i (tmr_dec),
        .zero_o(tmr_zero)
    );

    assign d_req = d_read | d_write;
    // A port in its ack cycle is masked even if it still holds its request.
    assign if_elig = if_req & ~if_ack_q;
    assign d_elig  = d_req & ~d_ack_q;

    always_comb begin
        pick_data = d_elig;
        if (if_elig && d_elig) begin
            pick_data = (RR_MODE == 0) ? 1'b1 : (last_q == GNT_FETCH);
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        op_d        = op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = err_q | (d_read & d_write);
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (if_elig || d_elig) begin
                    state_d  = ACCESS;
                    tmr_load = 1'b1;
                    if (pick_data) begin
                        gnt_d       = GNT_DATA;
                        last_d      = GNT_DATA;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        op_d        = d_write ? OP_WR : OP_RD;
                        mem_write_d = d_write;
                        mem_read_d  = ~d_write;
                    end else begin
                        gnt_d       = GNT_FETCH;
                        last_d      = GNT_FETCH;
                        mem_addr_d  = if_addr;
                        op_d        = OP_RD;
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (tmr_zero) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (gnt_q == GNT_DATA) begin
                        d_ack_d = 1'b1;
                        if (op_q == OP_RD) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pc_reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_FETCH;
            last_q      <= GNT_FETCH;
            op_q        <= OP_RD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            op_q        <= op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

    assign stall     = ~pc_reset & ((if_req & ~if_ack_q) | (d_req & ~d_ack_q));
    assign err       = err_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (fixed priority and round-robin) with a timeline reference model.
module tb_mem_port_arbiter;

    localparam int L = 2;

    typedef struct {
        int          g;
        int          port;     // 0 = fetch, 1 = data
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cyc;  // -1 while waiting for a grant
    } txn_t;

    logic        clk = 1'b0;
    logic        pc_reset;
    logic        if_req [2];
    logic        d_read [2];
    logic        d_write[2];
    logic [31:0] if_addr[2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata[2];
    logic [31:0] if_rdata[2];
    logic [31:0] d_rdata[2];
    logic        if_ack[2];
    logic        d_ack [2];
    logic        stall [2];
    logic        err   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic        mem_read [2];
    logic        mem_write[2];
    logic [31:0] mem_rdata[2];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    txn_t sb[$];

    int          free_at  [2];
    logic        last_data[2];
    logic        err_m    [2];
    logic        post_rst [2];
    logic [31:0] if_rd_m  [2];
    logic [31:0] d_rd_m   [2];
    logic        h_rd [2][16];
    logic        h_wr [2][16];
    logic [31:0] h_addr[2][16];
    logic [31:0] h_wd  [2][16];

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign mem_rdata[g] = mem_read[g] ? memf(mem_addr[g]) : 32'h0BAD_0BAD;
        mem_port_arbiter #(
            .AW(32), .DW(32), .MEM_LATENCY(L), .RR_MODE(g)
        ) u_dut (
            .clk(clk), .pc_reset(pc_reset),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
            .d_read(d_read[g]), .d_write(d_write[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_rdata(d_rdata[g]), .d_ack(d_ack[g]), .stall(stall[g]), .err(err[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_read(mem_read[g]),
            .mem_write(mem_write[g]), .mem_rdata(mem_rdata[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int find(input int g, input int p);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].g == g && sb[i].port == p) return i;
        return -1;
    endfunction

    task automatic wait_ack(input int g, input int p, input string nm);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (p == 1) ? d_ack[g] : if_ack[g];
        end
        if (!seen) chk({nm, "_ack_timeout"}, seen, 1'b1);
    endtask

    task automatic do_fetch(input int g, input logic [31:0] a);
        txn_t t;
        @(posedge clk); #1;
        if_req[g] = 1'b1; if_addr[g] = a;
        t.g = g; t.port = 0; t.wr = 1'b0; t.addr = a; t.wdata = '0;
        t.rdata = memf(a); t.ack_cyc = -1;
        sb.push_back(t);
        wait_ack(g, 0, "if");
        @(posedge clk); #1;
        if_req[g] = 1'b0; if_addr[g] = $urandom;
    endtask

    task automatic do_data(input int g, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        @(posedge clk); #1;
        d_read[g] = rd; d_write[g] = wr; d_addr[g] = a; d_wdata[g] = wd;
        t.g = g; t.port = 1; t.wr = wr; t.addr = a; t.wdata = wd;
        t.rdata = memf(a); t.ack_cyc = -1;
        sb.push_back(t);
        wait_ack(g, 1, "d");
        @(posedge clk); #1;
        d_read[g] = 1'b0; d_write[g] = 1'b0; d_wdata[g] = $urandom;
    endtask

    task automatic rand_fetch(input int g);
        repeat (60) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_fetch(g, $urandom & 32'h0000_FFFC);
        end
    endtask

    task automatic rand_data(input int g);
        int r;
        repeat (60) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            r = $urandom_range(0, 15);
            do_data(g, (r == 0) || (r < 8), (r == 0) || (r >= 8),
                    $urandom & 32'h0000_FFFC, $urandom);
        end
    endtask

    task automatic check_inst(input int g);
        int   slot, idx, fi, di, s;
        logic exp_stall, act, ok, pick;
        slot = cyc & 15;
        h_rd[g][slot] = mem_read[g];  h_wr[g][slot] = mem_write[g];
        h_addr[g][slot] = mem_addr[g]; h_wd[g][slot] = mem_wdata[g];

        if (pc_reset) begin
            chk("stall_in_reset", stall[g], 1'b0);
            for (int i = 0; i < sb.size(); i++)
                if (sb[i].g == g) sb[i].ack_cyc = -1;
            free_at[g] = cyc + 1; last_data[g] = 1'b0; err_m[g] = 1'b0;
            if_rd_m[g] = '0; d_rd_m[g] = '0; post_rst[g] = 1'b1;
            return;
        end

        if (post_rst[g]) begin
            chk("post_reset_bus", {mem_addr[g], mem_wdata[g], mem_read[g], mem_write[g],
                                   if_ack[g], d_ack[g]}, '0);
            chk("post_reset_rdata", {if_rdata[g], d_rdata[g]}, '0);
            post_rst[g] = 1'b0;
        end

        exp_stall = 1'b0;
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].g == g && sb[i].ack_cyc != cyc) exp_stall = 1'b1;
        chk("stall", stall[g], exp_stall);
        chk("err", err[g], err_m[g]);
        err_m[g] = err_m[g] | (d_read[g] & d_write[g]);
        chk("strobe_exclusive", mem_read[g] & mem_write[g], 1'b0);

        for (int p = 0; p < 2; p++) begin
            act = (p == 1) ? d_ack[g] : if_ack[g];
            idx = find(g, p);
            if (act) begin
                if (idx < 0) begin
                    chk(p ? "d_ack_unexpected" : "if_ack_unexpected", act, 1'b0);
                end else begin
                    chk(p ? "d_ack_cycle" : "if_ack_cycle", cyc, sb[idx].ack_cyc);
                    if (!sb[idx].wr) begin
                        if (p == 1) d_rd_m[g] = sb[idx].rdata;
                        else        if_rd_m[g] = sb[idx].rdata;
                    end
                    ok = !h_rd[g][slot] && !h_wr[g][slot] &&
                         !h_rd[g][(cyc - L - 1) & 15] && !h_wr[g][(cyc - L - 1) & 15];
                    for (int k = 1; k <= L; k++) begin
                        s = (cyc - k) & 15;
                        if (h_rd[g][s] !== !sb[idx].wr || h_wr[g][s] !== sb[idx].wr ||
                            h_addr[g][s] !== sb[idx].addr ||
                            (sb[idx].wr && h_wd[g][s] !== sb[idx].wdata)) ok = 1'b0;
                    end
                    chk(sb[idx].wr ? "bus_write_window" : "bus_read_window", ok, 1'b1);
                    sb.delete(idx);
                end
            end else if (idx >= 0 && sb[idx].ack_cyc == cyc) begin
                chk(p ? "d_ack_missing" : "if_ack_missing", act, 1'b1);
                sb.delete(idx);
            end
        end

        chk("if_rdata", if_rdata[g], if_rd_m[g]);
        chk("d_rdata", d_rdata[g], d_rd_m[g]);

        // One access occupies the port for L+1 cycles; the next grant decision is taken in its ack cycle.
        if (cyc >= free_at[g]) begin
            fi = find(g, 0); di = find(g, 1);
            if (fi >= 0 && sb[fi].ack_cyc >= 0) fi = -1;
            if (di >= 0 && sb[di].ack_cyc >= 0) di = -1;
            if (fi >= 0 || di >= 0) begin
                pick = (di >= 0) && (fi < 0 || g == 0 || !last_data[g]);
                idx = pick ? di : fi;
                sb[idx].ack_cyc = cyc + L + 1;
                free_at[g] = cyc + L + 1;
                last_data[g] = pick;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) check_inst(g);
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        pc_reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            if_req[g] = 1'b0; d_read[g] = 1'b0; d_write[g] = 1'b0;
            if_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
            free_at[g] = 0; last_data[g] = 1'b0; err_m[g] = 1'b0; post_rst[g] = 1'b1;
            if_rd_m[g] = '0; d_rd_m[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1 pc_reset = 1'b0;

        fork do_fetch(0, 32'h10); do_fetch(1, 32'h10); join
        fork
            do_fetch(0, 32'h14); do_data(0, 1'b1, 1'b0, 32'h30, '0);
            do_fetch(1, 32'h14); do_data(1, 1'b1, 1'b0, 32'h30, '0);
        join
        fork do_data(0, 1'b1, 1'b0, 32'h34, '0); do_data(1, 1'b1, 1'b0, 32'h34, '0); join
        fork
            do_fetch(0, 32'h18); do_data(0, 1'b1, 1'b0, 32'h38, '0);
            do_fetch(1, 32'h18); do_data(1, 1'b1, 1'b0, 32'h38, '0);
        join
        fork
            do_data(0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
            do_data(1, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
        join
        fork
            do_data(0, 1'b1, 1'b1, 32'h24, 32'h1234_5678);
            do_data(1, 1'b1, 1'b1, 32'h24, 32'h1234_5678);
        join
        fork
            do_fetch(0, 32'h44);
            do_fetch(1, 32'h44);
            begin
                @(posedge clk);
                repeat (2) @(posedge clk);
                #1 pc_reset = 1'b1;
                @(posedge clk);
                #1 pc_reset = 1'b0;
            end
        join

        fork rand_fetch(0); rand_data(0); rand_fetch(1); rand_data(1); join

        repeat (10) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
